// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target exposing a byte-addressed register file with local write port
// Optional SCL/SDA glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         MEM_DEPTH  = 256,
  parameter int         FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i2c_scl_i,
  output logic       i2c_scl_o,
  output logic       i2c_scl_t,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  output logic       i2c_sda_t,
  input  logic       loc_wr_en,
  input  logic [7:0] loc_wr_addr,
  input  logic [7:0] loc_wr_data,
  output logic       bus_wr_valid,
  output logic [7:0] bus_wr_addr,
  output logic [7:0] bus_wr_data,
  output logic       busy
);

  localparam int         AW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [8:0] DEPTH9 = 9'(MEM_DEPTH);

  if (MEM_DEPTH < 1 || MEM_DEPTH > 256 || FILTER_LEN < 1) begin : g_bad_param
    $error("i2c_target_regfile: MEM_DEPTH must be 1..256 and FILTER_LEN >= 1");
  end

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_s, sda_s, scl_q, sda_q;
  logic [3:0]  cnt;
  logic [7:0]  sh, ptr, rd_addr, rd_byte;
  logic [6:0]  rd_sh;
  logic        rw_q, sda_nxt, wr_fire, ptr_ok;
  logic [7:0]  mem [MEM_DEPTH];

  assign i2c_scl_o = 1'b1;
  assign i2c_scl_t = 1'b1;
  assign i2c_sda_t = i2c_sda_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], i2c_scl_i};
      sda_sync <= {sda_sync[0], i2c_sda_i};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);
  logic [1:0]          filt, raw;
  logic [1:0][FCW-1:0] fcnt;

  assign raw = {scl_sync[1], sda_sync[1]};

  // A line's filtered level follows the raw level only after FILTER_LEN differing samples in a row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 2'b11;
      fcnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCW'(FILTER_LEN - 1)) begin
          filt[i] <= raw[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign scl_s = filt[1];
  assign sda_s = filt[0];
`else
  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];
`endif

  wire scl_rise = scl_s & ~scl_q;
  wire scl_fall = ~scl_s & scl_q;
  wire start    = scl_s & scl_q & sda_q & ~sda_s;
  wire stop     = scl_s & scl_q & ~sda_q & sda_s;
  wire addr_hit = (sh[7:1] == DEV_ADDR);

  assign ptr_ok  = ({1'b0, ptr} < DEPTH9);
  assign rd_addr = (state == RD_ACK) ? ptr + 8'd1 : ptr;
  assign rd_byte = ({1'b0, rd_addr} < DEPTH9) ? mem[rd_addr[AW-1:0]] : 8'hFF;
  assign wr_fire = (state == WR_DATA) && scl_fall && (cnt == 4'd8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ADDR;
    end else if (stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        ADDR:     if (scl_fall && cnt == 4'd8) state_nxt = addr_hit ? ADDR_ACK : IGNORE;
        ADDR_ACK: if (scl_fall) state_nxt = rw_q ? RD_DATA : PTR;
        PTR:      if (scl_fall && cnt == 4'd8) state_nxt = PTR_ACK;
        PTR_ACK:  if (scl_fall) state_nxt = WR_DATA;
        WR_DATA:  if (scl_fall && cnt == 4'd8) state_nxt = WR_ACK;
        WR_ACK:   if (scl_fall) state_nxt = WR_DATA;
        RD_DATA:  if (scl_fall && cnt == 4'd7) state_nxt = RD_ACK;
        // A NACK ends the read at the 9th rising edge; an ACK resumes data at the 9th falling edge
        RD_ACK: begin
          if (scl_rise && sda_s) state_nxt = IGNORE;
          else if (scl_fall)     state_nxt = RD_DATA;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    sda_nxt = i2c_sda_o;
    if (start || stop) begin
      sda_nxt = 1'b1;
    end else if (scl_fall) begin
      case (state)
        ADDR:             sda_nxt = !((cnt == 4'd8) && addr_hit);
        ADDR_ACK:         sda_nxt = rw_q ? rd_byte[7] : 1'b1;
        PTR, WR_DATA:     sda_nxt = (cnt != 4'd8);
        RD_DATA:          sda_nxt = (cnt == 4'd7) ? 1'b1 : rd_sh[6];
        RD_ACK:           sda_nxt = rd_byte[7];
        default:          sda_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q        <= 1'b1;
      sda_q        <= 1'b1;
      cnt          <= '0;
      sh           <= '0;
      rw_q         <= 1'b0;
      ptr          <= '0;
      rd_sh        <= '0;
      i2c_sda_o    <= 1'b1;
      bus_wr_valid <= 1'b0;
      bus_wr_addr  <= '0;
      bus_wr_data  <= '0;
      busy         <= 1'b0;
    end else begin
      scl_q        <= scl_s;
      sda_q        <= sda_s;
      i2c_sda_o    <= sda_nxt;
      bus_wr_valid <= 1'b0;
      busy         <= (state_nxt != IDLE) && (state_nxt != IGNORE) &&
                      (busy || state_nxt == ADDR_ACK);
      if (start || state_nxt != state)                       cnt <= '0;
      else if ((state == RD_DATA) ? scl_fall : scl_rise)     cnt <= cnt + 4'd1;
      if (scl_rise) sh <= {sh[6:0], sda_s};
      if (state == ADDR && scl_fall && cnt == 4'd8) rw_q <= sh[0];
      if (state == PTR && scl_fall && cnt == 4'd8) ptr <= sh;
      if (wr_fire) begin
        ptr          <= ptr + 8'd1;
        bus_wr_valid <= ptr_ok;
        bus_wr_addr  <= ptr;
        bus_wr_data  <= sh;
      end
      if (state == RD_ACK && scl_fall && !start && !stop) ptr <= ptr + 8'd1;
      if (scl_fall && ((state == ADDR_ACK && rw_q) || state == RD_ACK)) rd_sh <= rd_byte[6:0];
      else if (scl_fall && state == RD_DATA)                             rd_sh <= {rd_sh[5:0], 1'b1};
    end
  end

  // Bus write is placed last so it overrides a same-cycle local write to the same byte
  always_ff @(posedge clk) begin
    if (loc_wr_en && ({1'b0, loc_wr_addr} < DEPTH9)) mem[loc_wr_addr[AW-1:0]] <= loc_wr_data;
    if (wr_fire && ptr_ok)                           mem[ptr[AW-1:0]] <= sh;
  end

endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- I2C target (responder) for the open-drain I2C interface the FPGA core drives as a controller; it is the other end of that bus.
- Provides a byte-addressed register file on the I2C bus, used to emulate QSFP/board management devices in benches and loopback builds.
- Local logic can preload or update bytes through a write port.
- Bus writes are reported on a strobe output.

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address matched after START.
- MEM_DEPTH, 256, number of implemented bytes (1..256); the pointer is always 8 bits.
- FILTER_LEN, 4, stable-sample count for the glitch filter; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i2c_scl_i  in  1  SCL pad input.
- i2c_scl_o  out  1  SCL output, constant 1.
- i2c_scl_t  out  1  SCL tristate, constant 1 (released).
- i2c_sda_i  in  1  SDA pad input.
- i2c_sda_o  out  1  SDA output; 0 = drive low.
- i2c_sda_t  out  1  SDA tristate; equals i2c_sda_o (1 = released).
- loc_wr_en  in  1  local write strobe.
- loc_wr_addr  in  8  local write byte address.
- loc_wr_data  in  8  local write data.
- bus_wr_valid  out  1  one-cycle pulse per bus-written byte.
- bus_wr_addr  out  8  byte address of the bus write.
- bus_wr_data  out  8  data of the bus write.
- busy  out  1  high from an address-matched START to STOP or NACK-exit.

Behaviour:
- Reset (rst_n low, asynchronous):
  - i2c_sda_o = i2c_sda_t = 1.
  - bus_wr_valid = 0, busy = 0.
  - Pointer = 0, state = IDLE.
  - Memory contents are not reset.
- Input conditioning:
  - SCL and SDA pass through 2-flop synchronizers.
  - Edges are detected against the previous synchronized sample.
- Bus conditions:
  - START or repeated START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - Both are detected in any state.
  - START goes to ADDR with the bit counter cleared. STOP goes to IDLE.
  - Both release SDA in the next cycle.
- Bit timing:
  - Sample SDA on the SCL rising edge, MSB first.
  - Change the SDA drive in the cycle after the SCL falling edge is detected.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7-bit address plus R/W). After the 8th falling edge:
    - Match: drive ACK (SDA low) and go to ADDR_ACK.
    - Mismatch: keep SDA released and go to IGNORE.
  - ADDR_ACK: on the 9th falling edge, release SDA.
    - R/W=0: go to PTR.
    - R/W=1: load the byte at the pointer and go to RD_DATA.
  - PTR: shift 8 bits, load the pointer, ACK, then go to WR_DATA.
  - WR_DATA: shift 8 bits, ACK, write the byte at the pointer, pulse bus_wr_valid in the cycle after the 8th falling edge, then increment the pointer.
  - RD_DATA: drive the 8 bits MSB first; drive 1 as released, never as driven high.
  - RD_ACK: release SDA and sample the controller's ACK on the 9th rising edge.
    - ACK: increment the pointer, load the next byte, return to RD_DATA.
    - NACK: go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- Pointer:
  - 8-bit, wraps 8'hFF to 8'h00.
  - Persists across transactions; a read without a pointer phase continues from the last pointer.
  - Pointer >= MEM_DEPTH: writes are ACKed but discarded, with no bus_wr_valid; reads return 8'hFF.
- Write collision: if a local write and a bus write target the same byte in the same cycle, the bus write wins. Different addresses both complete.
- Reset mid-transfer: SDA is released immediately (asynchronously). After reset, the block ignores the bus until the next START.
- busy falls in the cycle the block enters IDLE or IGNORE.

Optional Feature:
- Macro: I2C_TARGET_GLITCH_FILTER_EN.
- Defined: after the synchronizers, each line's filtered value changes only after FILTER_LEN consecutive equal samples. Pulses shorter than FILTER_LEN clk are rejected. Edge-to-response latency grows by FILTER_LEN cycles.
- Undefined: synchronizers only; FILTER_LEN is unused.

Test Plan:
- Write 0xA0 (addr 0x50, W), pointer 0x10, data 0x11, 0x22, STOP -> ACK on all 4 bytes; bus_wr_valid pulses with (0x10,0x11) then (0x11,0x22); memory updated; busy low after STOP.
- Preload byte 0xFF=0x5A, byte 0x00=0xC3 via the local port; write pointer 0xFF; repeated START; 0xA1; read 2 bytes (ACK, then NACK) -> reads 0x5A then 0xC3 (wrap); SDA released after the NACK.
- Address 0xA2 (0x51) -> no ACK (SDA stays 1 through the 9th clock); no memory change; busy stays 0.
- MEM_DEPTH=16: write pointer 0x20, data 0x77 -> ACKed, no bus_wr_valid; reading the same pointer returns 0xFF.
- Assert rst_n low during the ACK bit of a write -> SDA released in the same cycle; after release, a full write transaction completes normally.
- With I2C_TARGET_GLITCH_FILTER_EN and FILTER_LEN=4: a 2-clk low glitch on SDA while SCL is high -> no START detected, state unchanged. Without the macro, the same glitch is detected as START.
